qrd_ctrl: RTL and testbench

- Sequencer for the 4x4 complex QR-decomposition systolic array (three cascaded CORDIC PE stages).
- Accepts a stream of matrix columns under in_valid and tracks each column through the fixed-latency stages.
- Per stage, it issues a data-valid strobe and a vectoring-mode strobe on the first column of each matrix.
- Generates out_valid and an output column index and frame_done at the array output. It carries no datapath itself, only control.

---
 rtl/qrd_ctrl.sv | 148 ++++++++++++++
 tb/tb_qrd_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/qrd_ctrl.sv
// qrd_ctrl: control sequencer for the 4x4 complex QR-decomposition systolic
// array. It tracks each accepted column through N_STAGE cascaded CORDIC PE
// stages with a token delay line, drives per-stage valid/vectoring strobes,
// and flags the array output. It carries no datapath, only control.
module qrd_ctrl #(
  parameter int PE_LAT  = 4,
  parameter int N_STAGE = 3,
  parameter int N_COL   = 4
) (
  input  logic               clk,
  input  logic               rst_n,      // active-high asynchronous reset
  input  logic               in_valid,
  output logic               in_ready,
  output logic [N_STAGE-1:0] stage_vld,
  output logic [N_STAGE-1:0] stage_vec,
  output logic               out_valid,
  output logic [1:0]         out_col,
  output logic               frame_done,
  output logic               busy
);

  localparam int         TOT      = N_STAGE * PE_LAT;
  localparam logic [6:0] GAP_MAX  = 7'd64;
  localparam logic [1:0] LAST_COL = 2'(N_COL - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  // One token per cycle travels the delay line; vld=0 marks a bubble.
  typedef struct packed {
    logic       vld;
    logic       vec;
    logic [1:0] col;
    logic       abort;
    logic       fid;
  } tok_t;

  logic [1:0] state;
  logic       rdy_en;      // holds in_ready low until the first clock after reset
  logic [1:0] in_col_cnt;
  logic [6:0] gap_cnt;
  logic       frame_id;    // toggles per started matrix
  logic       accept, first, flush_go, pipe_busy;

  tok_t launch;
  tok_t pipe    [1:TOT];   // pipe[i] = token launched i cycles ago
  tok_t pipe_in [1:TOT];

  assign in_ready = rdy_en & (state != S_FLUSH);
  assign accept   = in_valid & in_ready;
  assign first    = (in_col_cnt == 2'd0);
  assign flush_go = (state == S_LOAD) & ~accept & (gap_cnt == GAP_MAX);

  // Token entering the delay line this cycle.
  always_comb begin
    launch = '0;
    if (accept) begin
      launch.vld = 1'b1;
      launch.vec = first;
      launch.col = in_col_cnt;
      launch.fid = first ? ~frame_id : frame_id;
    end
  end

  // Shift inputs; on flush entry, tokens of the current frame get aborted.
  always_comb begin
    for (int i = 1; i <= TOT; i++) begin
      pipe_in[i] = (i == 1) ? launch : pipe[(i > 1) ? i - 1 : 1];
      if (flush_go && pipe_in[i].vld && (pipe_in[i].fid == frame_id))
        pipe_in[i].abort = 1'b1;
    end
  end

  // Any valid token still in flight.
  always_comb begin
    pipe_busy = 1'b0;
    for (int i = 1; i <= TOT; i++) pipe_busy = pipe_busy | pipe[i].vld;
  end

  // Token delay line.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 1; i <= TOT; i++) pipe[i] <= '0;
    end else begin
      for (int i = 1; i <= TOT; i++) pipe[i] <= pipe_in[i];
    end
  end

  // Load FSM, column counter, gap timer and frame id.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state      <= S_IDLE;
      rdy_en     <= 1'b0;
      in_col_cnt <= 2'd0;
      gap_cnt    <= 7'd0;
      frame_id   <= 1'b0;
    end else begin
      rdy_en <= 1'b1;
      if (accept && first) frame_id <= ~frame_id;
      case (state)
        S_IDLE: begin
          gap_cnt <= 7'd0;
          if (accept) begin
            in_col_cnt <= in_col_cnt + 2'd1;
            if (first) state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (flush_go) begin
            state      <= S_FLUSH;
            in_col_cnt <= 2'd0;
            gap_cnt    <= 7'd0;
          end else if (accept) begin
            in_col_cnt <= in_col_cnt + 2'd1;
            gap_cnt    <= 7'd0;
            if (in_col_cnt == LAST_COL) state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 7'd1;
          end
        end
        S_FLUSH: begin
          gap_cnt <= 7'd0;
          if (!pipe_busy) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stage 0 strobes come straight from the accept; later stages tap flops.
  assign stage_vld[0] = accept;
  assign stage_vec[0] = accept & first;

  genvar k;
  generate
    for (k = 1; k < N_STAGE; k++) begin : g_tap
      assign stage_vld[k] = pipe[k*PE_LAT].vld;
      assign stage_vec[k] = pipe[k*PE_LAT].vec;
    end
  endgenerate

  assign out_valid  = pipe[TOT].vld & ~pipe[TOT].abort;
  assign out_col    = pipe[TOT].col;
  assign frame_done = out_valid & (out_col == LAST_COL);
  assign busy       = (state != S_IDLE) | pipe_busy;

endmodule

// File: tb/tb_qrd_ctrl.sv
// Directed bench for qrd_ctrl: PE_LAT=4 main instance plus a PE_LAT=1 instance.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_qrd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_valid1;
  logic       in_ready, in_ready1;
  logic [2:0] stage_vld, stage_vec, stage_vld1, stage_vec1;
  logic       out_valid, out_valid1;
  logic [1:0] out_col, out_col1;
  logic       frame_done, frame_done1;
  logic       busy, busy1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  qrd_ctrl #(.PE_LAT(4), .N_STAGE(3), .N_COL(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stage_vld(stage_vld), .stage_vec(stage_vec), .out_valid(out_valid),
    .out_col(out_col), .frame_done(frame_done), .busy(busy));

  qrd_ctrl #(.PE_LAT(1), .N_STAGE(3), .N_COL(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .stage_vld(stage_vld1), .stage_vec(stage_vec1), .out_valid(out_valid1),
    .out_col(out_col1), .frame_done(frame_done1), .busy(busy1));

  task automatic test_reset();
    n_chk++;
    if ({in_ready, stage_vld, stage_vec, out_valid, out_col, frame_done, busy} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_outputs got %b exp 0",
               {in_ready, stage_vld, stage_vec, out_valid, out_col, frame_done, busy});
    end
    n_chk++;
    if (in_ready1 !== 1'b0) begin n_fail++; $display("FAIL reset_ready1 got %b exp 0", in_ready1); end
    rst_n = 1'b0;
    #2;
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_release_cycle got %b exp 0", in_ready); end
    @(posedge clk); #1;
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_release got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    logic [2:0] ev, evld;
    for (int c = 0; c < 20; c++) begin
      in_valid = (c < 4);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        ev[k]   = (c == 4*k);
        evld[k] = (c >= 4*k) && (c < 4*k + 4);
      end
      n_chk++;
      if (stage_vec !== ev) begin n_fail++; $display("FAIL single_vec c=%0d got %b exp %b", c, stage_vec, ev); end
      n_chk++;
      if (stage_vld !== evld) begin n_fail++; $display("FAIL single_vld c=%0d got %b exp %b", c, stage_vld, evld); end
      n_chk++;
      if (out_valid !== (c >= 12 && c <= 15)) begin n_fail++; $display("FAIL single_ov c=%0d got %b", c, out_valid); end
      if (c >= 12 && c <= 15) begin
        n_chk++;
        if (out_col !== 2'(c - 12)) begin n_fail++; $display("FAIL single_col c=%0d got %0d exp %0d", c, out_col, c - 12); end
      end
      n_chk++;
      if (frame_done !== (c == 15)) begin n_fail++; $display("FAIL single_fd c=%0d got %b", c, frame_done); end
      n_chk++;
      if (busy !== (c >= 1 && c <= 15)) begin n_fail++; $display("FAIL single_busy c=%0d got %b", c, busy); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 24; c++) begin
      in_valid = (c < 8);
      @(negedge clk);
      n_chk++;
      if (out_valid !== (c >= 12 && c <= 19)) begin n_fail++; $display("FAIL b2b_ov c=%0d got %b", c, out_valid); end
      if (c >= 12 && c <= 19) begin
        n_chk++;
        if (out_col !== 2'((c - 12) % 4)) begin n_fail++; $display("FAIL b2b_col c=%0d got %0d exp %0d", c, out_col, (c - 12) % 4); end
      end
      n_chk++;
      if (frame_done !== (c == 15 || c == 19)) begin n_fail++; $display("FAIL b2b_fd c=%0d got %b", c, frame_done); end
      n_chk++;
      if (stage_vec[1] !== (c == 4 || c == 8)) begin n_fail++; $display("FAIL b2b_vec1 c=%0d got %b", c, stage_vec[1]); end
      n_chk++;
      if (stage_vec[0] !== (c == 0 || c == 4)) begin n_fail++; $display("FAIL b2b_vec0 c=%0d got %b", c, stage_vec[0]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_gapped();
    int ecol = 0;
    for (int c = 0; c < 24; c++) begin
      in_valid = (c == 0 || c == 2 || c == 5 || c == 6);
      @(negedge clk);
      n_chk++;
      if (out_valid !== (c == 12 || c == 14 || c == 17 || c == 18)) begin
        n_fail++; $display("FAIL gap_ov c=%0d got %b", c, out_valid);
      end
      if (c == 12 || c == 14 || c == 17 || c == 18) begin
        n_chk++;
        if (out_col !== 2'(ecol)) begin n_fail++; $display("FAIL gap_col c=%0d got %0d exp %0d", c, out_col, ecol); end
        ecol++;
      end
      n_chk++;
      if (stage_vec[2] !== (c == 8)) begin n_fail++; $display("FAIL gap_vec2 c=%0d got %b", c, stage_vec[2]); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_abort();
    int c = 0;
    int flush_c = -1;
    int fd_cnt = 0;
    int ov_after = 0;
    bit back = 0;
    for (int t = 0; t < 100; t++) begin
      in_valid = (c < 2);
      @(negedge clk);
      if (frame_done) fd_cnt++;
      if (!in_ready) begin flush_c = c; break; end
      @(posedge clk); #1;
      c++;
    end
    n_chk++;
    if (flush_c !== 67) begin n_fail++; $display("FAIL abort_flush_cycle got %0d exp 67", flush_c); end
    n_chk++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_flush got %b exp 1", busy); end
    for (int t = 0; t < 30; t++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (out_valid) ov_after++;
      if (frame_done) fd_cnt++;
      if (in_ready) begin back = 1; break; end
    end
    n_chk++;
    if (back !== 1'b1) begin n_fail++; $display("FAIL abort_ready_return got %b exp 1", back); end
    n_chk++;
    if (ov_after !== 0) begin n_fail++; $display("FAIL abort_ov_after_flush got %0d exp 0", ov_after); end
    n_chk++;
    if (fd_cnt !== 0) begin n_fail++; $display("FAIL abort_frame_done got %0d exp 0", fd_cnt); end
    @(posedge clk); #1;
    // New matrix after the abort must start in vectoring mode.
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      n_chk++;
      if (stage_vec[0] !== (k == 0)) begin n_fail++; $display("FAIL abort_restart_vec0 k=%0d got %b", k, stage_vec[0]); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int first_ov = -1;
    int ov_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c < 4);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    n_chk++;
    if ({stage_vld, stage_vec, out_valid, out_col, frame_done, busy, in_ready} !== 12'd0) begin
      n_fail++;
      $display("FAIL midreset_outputs got %b exp 0",
               {stage_vld, stage_vec, out_valid, out_col, frame_done, busy, in_ready});
    end
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    for (int c = 0; c < 30; c++) begin
      in_valid = (c < 4);
      @(negedge clk);
      if (out_valid) begin
        ov_cnt++;
        if (first_ov < 0) first_ov = c;
      end
      @(posedge clk); #1;
    end
    n_chk++;
    if (first_ov !== 12) begin n_fail++; $display("FAIL midreset_latency got %0d exp 12", first_ov); end
    n_chk++;
    if (ov_cnt !== 4) begin n_fail++; $display("FAIL midreset_ov_count got %0d exp 4", ov_cnt); end
  endtask

  task automatic test_pe_lat1();
    for (int c = 0; c < 10; c++) begin
      in_valid1 = (c < 4);
      @(negedge clk);
      n_chk++;
      if (out_valid1 !== (c >= 3 && c <= 6)) begin n_fail++; $display("FAIL pe1_ov c=%0d got %b", c, out_valid1); end
      if (c >= 3 && c <= 6) begin
        n_chk++;
        if (out_col1 !== 2'(c - 3)) begin n_fail++; $display("FAIL pe1_col c=%0d got %0d exp %0d", c, out_col1, c - 3); end
      end
      n_chk++;
      if (stage_vec1[1] !== (c == 1)) begin n_fail++; $display("FAIL pe1_vec1 c=%0d got %b", c, stage_vec1[1]); end
      n_chk++;
      if (stage_vec1[2] !== (c == 2)) begin n_fail++; $display("FAIL pe1_vec2 c=%0d got %b", c, stage_vec1[2]); end
      @(posedge clk); #1;
    end
    in_valid1 = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    in_valid1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_gapped();
    test_abort();
    test_reset_mid();
    test_pe_lat1();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
